// File: rtl/reg_scoreboard.sv
// Issue-control scoreboard: per-register countdown of pending writes,
// RAW stall generation and halt drain sequencing.
module reg_scoreboard #(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [2:0] id_rs,
  input  logic       id_rs_used,
  input  logic [2:0] id_rt,
  input  logic       id_rt_used,
  input  logic [2:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_halt,
  input  logic       flush,
  output logic       stall,
  output logic       issue,
  output logic [7:0] busy_mask,
  output logic       halted,
  output logic       err
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  localparam logic [CNT_W-1:0] LAT = CNT_W'(WB_LAT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic             hz;
  logic             is_run;

  // count == 1 lands this cycle and is bypassed, so only > 1 blocks.
  always_comb begin
    hz = (id_rs_used && (cnt_q[id_rs] > ONE)) ||
         (id_rt_used && (cnt_q[id_rt] > ONE));
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      busy_mask[i] = (cnt_q[i] != '0);
    end
  end

  always_comb begin
    stall  = 1'b1;
    issue  = 1'b0;
    halted = 1'b0;
    is_run = 1'b0;
    case (state_q)
      S_RUN: begin
        is_run = 1'b1;
        stall  = id_valid & hz;
        issue  = id_valid & ~hz & ~flush;
      end
      S_DRAIN: begin
        stall = 1'b1;
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        stall = 1'b1;
      end
    endcase
  end

  assign err = id_valid & halted;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (issue && id_reg_write && (id_rd == 3'(i))) begin
        cnt_d[i] = LAT;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (issue && id_halt) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (busy_mask == 8'h00) state_d = S_HALTED;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = is_run;

endmodule
